// File: rtl/mem_port_arbiter.sv
// Two-port (IF / MEM) arbiter in front of a single-port memory, one transaction in flight.
// Optional IF starvation guard is enabled with `define MEM_ARB_STARVE_GUARD_EN.
module mem_port_arbiter #(
    parameter int ADDR_WIDTH    = 32,
    parameter int DATA_WIDTH    = 32,
    parameter int MAX_MEM_BURST = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    if_req_i,
    input  logic [ADDR_WIDTH-1:0]   if_addr_i,
    output logic                    if_gnt_o,
    output logic                    if_rvalid_o,
    input  logic                    mem_req_i,
    input  logic                    mem_we_i,
    input  logic [ADDR_WIDTH-1:0]   mem_addr_i,
    input  logic [DATA_WIDTH-1:0]   mem_wdata_i,
    input  logic [DATA_WIDTH/8-1:0] mem_be_i,
    output logic                    mem_gnt_o,
    output logic                    mem_rvalid_o,
    output logic [DATA_WIDTH-1:0]   rdata_o,
    output logic                    ram_req_o,
    output logic                    ram_we_o,
    output logic [ADDR_WIDTH-1:0]   ram_addr_o,
    output logic [DATA_WIDTH-1:0]   ram_wdata_o,
    output logic [DATA_WIDTH/8-1:0] ram_be_o,
    input  logic                    ram_gnt_i,
    input  logic                    ram_rvalid_i,
    input  logic [DATA_WIDTH-1:0]   ram_rdata_i,
    output logic                    busy_o
);

    localparam int BE_WIDTH = DATA_WIDTH / 8;

    if (MAX_MEM_BURST < 1) begin : g_burst_check
        $error("MAX_MEM_BURST must be at least 1");
    end

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RSP} state_e;

    state_e                state_q, state_d;
    logic                  we_q, we_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [BE_WIDTH-1:0]   be_q, be_d;
    logic                  owner_mem_q, owner_mem_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                  if_rvalid_q, if_rvalid_d;
    logic                  mem_rvalid_q, mem_rvalid_d;
    logic                  pick_mem;
    logic                  pick_if;

`ifdef MEM_ARB_STARVE_GUARD_EN
    localparam int RUN_W = $clog2(MAX_MEM_BURST + 1);

    logic [RUN_W-1:0] mem_run_q, mem_run_d;
    logic             burst_full;

    // Once MEM has won MAX_MEM_BURST times in a row against a waiting IF, IF gets one turn.
    assign burst_full = (mem_run_q == RUN_W'(MAX_MEM_BURST));
    assign pick_mem   = mem_req_i && !(if_req_i && burst_full);

    always_comb begin
        mem_run_d = mem_run_q;
        if (state_q == IDLE) begin
            if (pick_if) begin
                mem_run_d = '0;
            end else if (pick_mem) begin
                if (!if_req_i) begin
                    mem_run_d = '0;
                end else if (!burst_full) begin
                    mem_run_d = mem_run_q + RUN_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_run_q <= '0;
        end else begin
            mem_run_q <= mem_run_d;
        end
    end
`else
    assign pick_mem = mem_req_i;
`endif

    assign pick_if = if_req_i && !pick_mem;

    always_comb begin
        state_d      = state_q;
        we_d         = we_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        be_d         = be_q;
        owner_mem_d  = owner_mem_q;
        rdata_d      = rdata_q;
        if_rvalid_d  = 1'b0;
        mem_rvalid_d = 1'b0;
        if_gnt_o     = 1'b0;
        mem_gnt_o    = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (pick_mem) begin
                    mem_gnt_o   = 1'b1;
                    we_d        = mem_we_i;
                    addr_d      = mem_addr_i;
                    wdata_d     = mem_wdata_i;
                    be_d        = mem_be_i;
                    owner_mem_d = 1'b1;
                    state_d     = ISSUE;
                end else if (pick_if) begin
                    if_gnt_o    = 1'b1;
                    we_d        = 1'b0;
                    addr_d      = if_addr_i;
                    wdata_d     = '0;
                    be_d        = {BE_WIDTH{1'b1}};
                    owner_mem_d = 1'b0;
                    state_d     = ISSUE;
                end
            end
            ISSUE: begin
                if (ram_gnt_i) begin
                    state_d = WAIT_RSP;
                end
            end
            WAIT_RSP: begin
                // Response data is registered, so the owner sees rvalid one cycle later.
                if (ram_rvalid_i) begin
                    rdata_d      = ram_rdata_i;
                    if_rvalid_d  = !owner_mem_q;
                    mem_rvalid_d = owner_mem_q;
                    state_d      = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            we_q         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            be_q         <= '0;
            owner_mem_q  <= 1'b0;
            rdata_q      <= '0;
            if_rvalid_q  <= 1'b0;
            mem_rvalid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            we_q         <= we_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            be_q         <= be_d;
            owner_mem_q  <= owner_mem_d;
            rdata_q      <= rdata_d;
            if_rvalid_q  <= if_rvalid_d;
            mem_rvalid_q <= mem_rvalid_d;
        end
    end

    assign ram_req_o    = (state_q == ISSUE);
    assign ram_we_o     = we_q;
    assign ram_addr_o   = addr_q;
    assign ram_wdata_o  = wdata_q;
    assign ram_be_o     = be_q;
    assign rdata_o      = rdata_q;
    assign if_rvalid_o  = if_rvalid_q;
    assign mem_rvalid_o = mem_rvalid_q;
    assign busy_o       = (state_q != IDLE);

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-port memory between two requesters of the pipelined core: instruction fetch (IF port) and load/store (MEM port).
- Only one transaction is outstanding at a time.
- Requests use a req/gnt handshake; responses come back as an rvalid pulse on the owning port.
- Sits between the IF/MEM stages and the unified memory model; its grant/rvalid timing drives the core's fetch and memory stalls.

Parameters:
- ADDR_WIDTH, 32, byte address width.
- DATA_WIDTH, 32, data width; byte-enable width is DATA_WIDTH/8.
- MAX_MEM_BURST, 4, consecutive MEM grants allowed while IF waits (used only with the optional feature; must be ≥1).

Ports:
- clk  in  1  clock
- rst  in  1  reset
- if_req_i  in  1  IF read request
- if_addr_i  in  ADDR_WIDTH  IF address
- if_gnt_o  out  1  IF request accepted (1-cycle pulse)
- if_rvalid_o  out  1  IF response valid (1-cycle pulse)
- mem_req_i  in  1  MEM request
- mem_we_i  in  1  MEM write enable
- mem_addr_i  in  ADDR_WIDTH  MEM address
- mem_wdata_i  in  DATA_WIDTH  MEM write data
- mem_be_i  in  DATA_WIDTH/8  MEM byte enables
- mem_gnt_o  out  1  MEM request accepted (pulse)
- mem_rvalid_o  out  1  MEM response valid (pulse; also signals write done)
- rdata_o  out  DATA_WIDTH  registered response data, shared by both ports
- ram_req_o  out  1  memory request
- ram_we_o  out  1  memory write
- ram_addr_o  out  ADDR_WIDTH  memory address
- ram_wdata_o  out  DATA_WIDTH  memory write data
- ram_be_o  out  DATA_WIDTH/8  memory byte enables
- ram_gnt_i  in  1  memory accepted request
- ram_rvalid_i  in  1  memory response valid
- ram_rdata_i  in  DATA_WIDTH  memory read data
- busy_o  out  1  state != IDLE

Behaviour:
- Clocking and reset: one clock; reset is asynchronous and active-high. All outputs and registers reset to 0, state resets to IDLE.
- FSM states: IDLE, ISSUE, WAIT_RSP.
- IDLE, arbitration:
  - If mem_req_i is high: mem_gnt_o=1 combinationally. Latch we/addr/wdata/be, set owner=MEM, go to ISSUE.
  - Else if if_req_i is high: if_gnt_o=1. Latch addr, set we=0, be=all ones, wdata=0, owner=IF, go to ISSUE.
  - Else stay in IDLE.
  - Gnt is asserted only in IDLE. A requester drops or changes its request after seeing gnt.
- ISSUE:
  - ram_req_o=1 and ram_* are driven from the latched registers; they are stable until ram_gnt_i.
  - On ram_gnt_i, go to WAIT_RSP.
- WAIT_RSP:
  - ram_req_o=0.
  - On ram_rvalid_i: register ram_rdata_i into rdata_o and go to IDLE.
  - In the next cycle, pulse the owner's rvalid for exactly 1 cycle.
- Latency: gnt in cycle T, ram_req_o at T+1; minimum response is owner rvalid at T+3. The IDLE cycle that shows rvalid may grant a new request.
- rdata_o holds its value until the next response.
- Boundary conditions:
  - ram_rvalid_i in IDLE or ISSUE is ignored. The memory must not respond in the same cycle as ram_gnt_i.
  - Both requests high in IDLE: MEM wins (data access first; avoids a pipeline deadlock where MEM stalls IF).
  - A request with no gnt stays pending; the requester holds it.
  - Reset mid-transaction aborts it. No rvalid is produced, and any late ram_rvalid_i is ignored in IDLE.
  - Writes: memory must still return ram_rvalid_i. mem_rvalid_o is the write ack; rdata_o is updated with whatever the memory returns.

Optional Feature:
- MEM_ARB_STARVE_GUARD_EN defined:
  - Counter mem_run tracks consecutive MEM grants made while if_req_i was high.
  - When mem_run == MAX_MEM_BURST and if_req_i is high in IDLE, IF is granted even if mem_req_i is high.
  - mem_run clears on any IF grant, or on a MEM grant with if_req_i low. It saturates at MAX_MEM_BURST.
- Not defined: strict MEM priority; no counter logic.

Test Plan:
- IF only: if_req_i=1, addr=0x100, memory grants immediately and responds 1 cycle later with 0xDEADBEEF. Expect if_gnt_o at T, ram_req_o/ram_addr_o=0x100 at T+1, if_rvalid_o at T+3, rdata_o=0xDEADBEEF.
- MEM write: we=1, addr=0x200, wdata=0x12345678, be=4'b0011. Expect ram_we_o=1 with matching addr/wdata/be until ram_gnt_i, then a single mem_rvalid_o pulse and no if_rvalid_o.
- Collision: both requests in the same IDLE cycle. Expect mem_gnt_o first and if_gnt_o in the IDLE cycle after mem_rvalid_o; a stalled memory (ram_gnt_i low for 5 cycles) holds ram_addr_o stable.
- Reset mid-WAIT_RSP: rst pulse, then ram_rvalid_i=1. Expect all outputs 0, state IDLE, and no rvalid pulse.
- With MEM_ARB_STARVE_GUARD_EN and MAX_MEM_BURST=4, both requests held high: expect grant order MEM,MEM,MEM,MEM,IF,MEM…
- Without the macro, same stimulus: all grants go to MEM.
